// File: rtl/chunked_addsub_pkg.sv
// Shared types and helpers for the chunked adder/subtractor.
package chunked_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Opcode encoding on the sub input.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Widest operand the saturation constants can be built for.
    localparam int MAX_SAT_W = 64;

    // Signed max (neg=0: 0111..1) or signed min (neg=1: 1000..0) for width w,
    // zero-extended to MAX_SAT_W bits.
    function automatic logic [MAX_SAT_W-1:0] sat_limit(input int w, input logic neg);
        logic [MAX_SAT_W-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_SAT_W; i++) begin
            if (i < w) begin
                v[i] = neg ? (i == w - 1) : (i != w - 1);
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/chunked_addsub_chunk_adder.sv
// CHUNK-bit combinational ripple-carry adder slice.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout
);

    logic [CHUNK:0] w_c;

    // Bit-serial ripple through the slice.
    always_comb begin
        w_c    = '0;
        o_sum  = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < CHUNK; i++) begin
            o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_c[CHUNK];
    end

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle WIDTH-bit add/sub, CHUNK bits per clock, LSB chunk first.
// Subtraction is a1 + ~a2 + 1: the +1 enters as the initial chunk carry.
module chunked_addsub
    import chunked_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter bit SAT   = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a1,
    input  logic [WIDTH-1:0] i_a2,
    input  logic             i_sub,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_q,
    output logic             o_carry,
    output logic             o_overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int MSB    = WIDTH - 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if (WIDTH < 1) begin : g_chk_width
        $error("chunked_addsub: WIDTH must be >= 1");
    end
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_chk_chunk
        $error("chunked_addsub: WIDTH must be a multiple of CHUNK");
    end

    state_t            r_state, w_next;
    logic [WIDTH-1:0]  r_a1, r_b, r_res;
    logic              r_cy;
    logic [IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_q;
    logic              r_carry, r_ovf;

    logic              w_accept, w_busy, w_last;
    int                w_base;
    logic [CHUNK-1:0]  w_ca, w_cb, w_sum;
    logic              w_cout;
    logic [WIDTH-1:0]  w_raw, w_qnext;
    logic              w_ovf;
    logic [WIDTH-1:0]  w_smax, w_smin;

    // Saturation constants only exist when clamping is enabled.
    if (SAT) begin : g_sat
        if (WIDTH > MAX_SAT_W) begin : g_chk_sat
            $error("chunked_addsub: SAT needs WIDTH <= MAX_SAT_W");
        end
        localparam logic [MAX_SAT_W-1:0] SMAX_F = sat_limit(WIDTH, 1'b0);
        localparam logic [MAX_SAT_W-1:0] SMIN_F = sat_limit(WIDTH, 1'b1);
        assign w_smax = SMAX_F[WIDTH-1:0];
        assign w_smin = SMIN_F[WIDTH-1:0];
    end else begin : g_nosat
        assign w_smax = '0;
        assign w_smin = '0;
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next-state and handshake decode.
    always_comb begin
        w_next      = r_state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        w_accept    = 1'b0;
        w_busy      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_accept = 1'b1;
                    w_next   = BUSY;
                end
            end
            BUSY: begin
                w_busy = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_last = 1'b1;
                    w_next = DONE;
                end
            end
            DONE: begin
                o_out_valid = 1'b1;
                if (i_out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Select the current chunk of each operand.
    assign w_base = int'(r_idx) * CHUNK;
    assign w_ca   = r_a1[w_base +: CHUNK];
    assign w_cb   = r_b[w_base +: CHUNK];

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .i_a    (w_ca),
        .i_b    (w_cb),
        .i_cin  (r_cy),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Full result as it will look once the current chunk is written.
    always_comb begin
        w_raw = r_res;
        w_raw[w_base +: CHUNK] = w_sum;
    end

    assign w_ovf = (r_a1[MSB] == r_b[MSB]) && (w_raw[MSB] != r_a1[MSB]);

    // Optional clamp toward the sign of a1 on signed overflow.
    always_comb begin
        w_qnext = w_raw;
        if (SAT && w_ovf) w_qnext = r_a1[MSB] ? w_smin : w_smax;
    end

    // Operand capture, per-chunk accumulation and final result capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a1    <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cy    <= 1'b0;
            r_idx   <= '0;
            r_q     <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a1  <= i_a1;
            r_b   <= (i_sub == OP_SUB) ? ~i_a2 : i_a2;
            r_cy  <= i_sub;
            r_idx <= '0;
            r_res <= '0;
        end else if (w_busy) begin
            r_res[w_base +: CHUNK] <= w_sum;
            r_cy                   <= w_cout;
            if (w_last) begin
                r_idx   <= '0;
                r_q     <= w_qnext;
                r_carry <= w_cout;
                r_ovf   <= w_ovf;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign o_q        = r_q;
    assign o_carry    = r_carry;
    assign o_overflow = r_ovf;

endmodule

// File: tb/tb_chunked_addsub.sv
// Scoreboard bench over four configurations of chunked_addsub:
// k=0 16/4 wrap, k=1 16/4 saturate, k=2 4/1, k=3 4/4.
module tb_chunked_addsub;

    localparam int W_OF   [4] = '{16, 16, 4, 4};
    localparam int NCH_OF [4] = '{4, 4, 4, 1};
    localparam bit SAT_OF [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    typedef struct {
        logic [15:0] q;
        logic        c;
        logic        o;
    } exp_t;

    logic        clk, rst_n;
    logic [3:0]  vin, rdy_in, vout, rdy_out, subv, cy, ovf;
    logic [15:0] a1 [4];
    logic [15:0] a2 [4];
    logic [15:0] q0, q1;
    logic [3:0]  q2, q3;

    int   errors, checks;
    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    chunked_addsub #(.WIDTH(16), .CHUNK(4), .SAT(1'b0)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(vin[0]), .o_in_ready(rdy_in[0]),
        .i_a1(a1[0]), .i_a2(a2[0]), .i_sub(subv[0]), .o_out_valid(vout[0]),
        .i_out_ready(rdy_out[0]), .o_q(q0), .o_carry(cy[0]), .o_overflow(ovf[0]));
    chunked_addsub #(.WIDTH(16), .CHUNK(4), .SAT(1'b1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(vin[1]), .o_in_ready(rdy_in[1]),
        .i_a1(a1[1]), .i_a2(a2[1]), .i_sub(subv[1]), .o_out_valid(vout[1]),
        .i_out_ready(rdy_out[1]), .o_q(q1), .o_carry(cy[1]), .o_overflow(ovf[1]));
    chunked_addsub #(.WIDTH(4), .CHUNK(1), .SAT(1'b0)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(vin[2]), .o_in_ready(rdy_in[2]),
        .i_a1(a1[2][3:0]), .i_a2(a2[2][3:0]), .i_sub(subv[2]), .o_out_valid(vout[2]),
        .i_out_ready(rdy_out[2]), .o_q(q2), .o_carry(cy[2]), .o_overflow(ovf[2]));
    chunked_addsub #(.WIDTH(4), .CHUNK(4), .SAT(1'b0)) u3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(vin[3]), .o_in_ready(rdy_in[3]),
        .i_a1(a1[3][3:0]), .i_a2(a2[3][3:0]), .i_sub(subv[3]), .o_out_valid(vout[3]),
        .i_out_ready(rdy_out[3]), .o_q(q3), .o_carry(cy[3]), .o_overflow(ovf[3]));

    function automatic logic [15:0] get_q(input int k);
        case (k)
            0:       return q0;
            1:       return q1;
            2:       return {12'd0, q2};
            default: return {12'd0, q3};
        endcase
    endfunction

    // Reference: full-width two's-complement arithmetic, not chunked.
    function automatic exp_t model(input int k, input logic [15:0] a, input logic [15:0] b,
                                   input logic s);
        exp_t        e;
        int          w, m;
        logic [16:0] mask, sum;
        logic [15:0] am, bb, raw;
        w    = W_OF[k];
        m    = w - 1;
        mask = (17'd1 << w) - 17'd1;
        am   = a & mask[15:0];
        bb   = s ? (~b & mask[15:0]) : (b & mask[15:0]);
        sum  = {1'b0, am} + {1'b0, bb} + {16'd0, s};
        raw  = sum[15:0] & mask[15:0];
        e.c  = sum[w];
        e.o  = (am[m] == bb[m]) && (raw[m] != am[m]);
        if (SAT_OF[k] && e.o) raw = am[m] ? (16'd1 << m) : ((16'd1 << m) - 16'd1);
        e.q  = raw;
        return e;
    endfunction

    task automatic start_op(input int k, input logic [15:0] a, input logic [15:0] b,
                            input logic s);
        @(negedge clk);
        checks++;
        if (rdy_in[k] !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready k=%0d got=%b want=1", k, rdy_in[k]);
        end
        vin[k]  = 1'b1;
        a1[k]   = a;
        a2[k]   = b;
        subv[k] = s;
        sb.push_back(model(k, a, b, s));
        @(posedge clk);
        @(negedge clk);
        vin[k] = 1'b0;
        checks++;
        if (rdy_in[k] !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready k=%0d got=%b want=0", k, rdy_in[k]);
        end
    endtask

    // Called at the negedge right after the accept edge.
    task automatic wait_result(input int k, output exp_t e, output bit ok);
        int cnt;
        cnt = 0;
        ok  = 1'b0;
        while (vout[k] !== 1'b1 && cnt < 64) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        e = sb.pop_front();
        checks++;
        if (vout[k] !== 1'b1) begin
            errors++;
            $display("FAIL timeout k=%0d out_valid never rose", k);
            return;
        end
        if (cnt != NCH_OF[k]) begin
            errors++;
            $display("FAIL latency k=%0d got=%0d want=%0d", k, cnt, NCH_OF[k]);
        end
        checks++;
        if (get_q(k) !== e.q) begin
            errors++;
            $display("FAIL q k=%0d got=%h want=%h", k, get_q(k), e.q);
        end
        checks++;
        if (cy[k] !== e.c) begin
            errors++;
            $display("FAIL carry k=%0d got=%b want=%b", k, cy[k], e.c);
        end
        checks++;
        if (ovf[k] !== e.o) begin
            errors++;
            $display("FAIL overflow k=%0d got=%b want=%b", k, ovf[k], e.o);
        end
        ok = 1'b1;
    endtask

    task automatic release_out(input int k);
        rdy_out[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy_out[k] = 1'b0;
        checks++;
        if (vout[k] !== 1'b0 || rdy_in[k] !== 1'b1) begin
            errors++;
            $display("FAIL handoff k=%0d out_valid=%b in_ready=%b want 0/1",
                     k, vout[k], rdy_in[k]);
        end
    endtask

    task automatic run(input int k, input logic [15:0] a, input logic [15:0] b,
                       input logic s);
        exp_t e;
        bit   ok;
        start_op(k, a, b, s);
        wait_result(k, e, ok);
        if (ok) release_out(k);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (vout[k] !== 1'b0 || rdy_in[k] !== 1'b1 || get_q(k) !== 16'd0 ||
                cy[k] !== 1'b0 || ovf[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset k=%0d ov=%b ir=%b q=%h c=%b o=%b want 0/1/0/0/0",
                         k, vout[k], rdy_in[k], get_q(k), cy[k], ovf[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        run(0, 16'h0001, 16'h0002, 1'b0);
        run(0, 16'h1234, 16'h4321, 1'b0);
    endtask

    task automatic test_wrap();
        run(0, 16'hFFFF, 16'h0001, 1'b0);
        run(0, 16'h7FFF, 16'h0001, 1'b0);
        run(1, 16'h7FFF, 16'h0001, 1'b0);
        run(1, 16'h8000, 16'hFFFF, 1'b0);
    endtask

    task automatic test_sub();
        run(0, 16'h0001, 16'h0002, 1'b1);
        run(0, 16'h8000, 16'h0001, 1'b1);
        run(1, 16'h8000, 16'h0001, 1'b1);
        run(0, 16'hABCD, 16'hABCD, 1'b1);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   ok;
        start_op(0, 16'h1234, 16'h0FF0, 1'b0);
        wait_result(0, e, ok);
        if (ok) begin
            for (int c = 0; c < 5; c++) begin
                if (c == 2) begin
                    vin[0] = 1'b1;
                    a1[0]  = 16'h5555;
                    a2[0]  = 16'h1111;
                end
                @(posedge clk);
                @(negedge clk);
                vin[0] = 1'b0;
                checks++;
                if (vout[0] !== 1'b1 || rdy_in[0] !== 1'b0 || q0 !== e.q ||
                    cy[0] !== e.c || ovf[0] !== e.o) begin
                    errors++;
                    $display("FAIL hold c=%0d ov=%b ir=%b q=%h c=%b o=%b want 1/0/%h/%b/%b",
                             c, vout[0], rdy_in[0], q0, cy[0], ovf[0], e.q, e.c, e.o);
                end
            end
            release_out(0);
        end
        run(0, 16'h00AA, 16'h0055, 1'b0);
        run(0, 16'h0100, 16'h0200, 1'b1);
    endtask

    task automatic test_reset_mid();
        start_op(0, 16'h0010, 16'h0001, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        checks++;
        if (vout[0] !== 1'b0 || rdy_in[0] !== 1'b1 || q0 !== 16'd0 ||
            cy[0] !== 1'b0 || ovf[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid ov=%b ir=%b q=%h c=%b o=%b want 0/1/0/0/0",
                     vout[0], rdy_in[0], q0, cy[0], ovf[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 16'h0005, 16'h0003, 1'b0);
    endtask

    task automatic test_generic();
        run(2, 16'h1, 16'h2, 1'b0);
        run(2, 16'h1, 16'h1, 1'b0);
        run(2, 16'hF, 16'h1, 1'b0);
        run(2, 16'h3, 16'h5, 1'b1);
        run(3, 16'h1, 16'h2, 1'b0);
        run(3, 16'h7, 16'h1, 1'b0);
        run(3, 16'h3, 16'h5, 1'b1);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        vin     = '0;
        rdy_out = '0;
        subv    = '0;
        for (int k = 0; k < 4; k++) begin
            a1[k] = '0;
            a2[k] = '0;
        end
        test_reset();
        test_add();
        test_wrap();
        test_sub();
        test_back_to_back();
        test_reset_mid();
        test_generic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chunked_addsub.md
Name: chunked_addsub

Overview:
Parametrised multi-cycle adder/subtractor for two WIDTH-bit operands a1 and a2. It processes CHUNK bits per clock, LSB chunk first, and keeps a registered carry between chunks. Operands enter through a valid/ready handshake. The result is held under a valid/ready output handshake with carry, signed-overflow and optional saturation. It is the sequential, width-generic successor of the 4-bit a1/a2 -> q combinational arithmetic top in the same exercise set.

Parameters:
WIDTH, 16, operand/result width in bits; must be >= 1.
CHUNK, 4, bits processed per cycle; WIDTH % CHUNK == 0 is required (elaboration-time check).
SAT, 0, 1 = clamp q to signed max/min on signed overflow; 0 = wrap.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand/opcode present
in_ready  out  1  block can accept an operation
a1  in  WIDTH  first operand
a2  in  WIDTH  second operand
sub  in  1  0 = a1+a2, 1 = a1-a2
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
q  out  WIDTH  result
carry  out  1  add: carry out; sub: 1 = no borrow (a1 >= a2 unsigned)
overflow  out  1  signed two's-complement overflow of the unclamped result

Behaviour:
- One clock. Asynchronous active-low reset: rst_n low forces state IDLE immediately.
- Reset values: q=0, carry=0, overflow=0, out_valid=0, chunk index=0, operand registers=0. in_ready=1, since in_ready is decoded from state==IDLE.
- Derived constant NCHUNK = WIDTH/CHUNK.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1, out_valid=0.
  - On in_valid && in_ready: latch a1, b = sub ? ~a2 : a2, carry_reg = sub, idx=0, and clear the result register. Next state BUSY.
- BUSY: in_ready=0, out_valid=0. in_valid is ignored.
  - Each cycle: chunk idx of a1 + chunk idx of b + carry_reg -> write result chunk idx; carry_reg <= chunk carry-out; idx++.
  - When idx == NCHUNK-1, that chunk is processed and the state moves to DONE.
  - Capture on that same edge: carry = final carry-out; overflow = (a1[MSB]==b[MSB]) && (raw[MSB]!=a1[MSB]); q = raw result.
  - If SAT=1 and overflow: q = a1[MSB] ? 1 followed by zeros (signed min) : 0 followed by ones (signed max).
- DONE: out_valid=1, in_ready=0. q, carry and overflow are held stable.
  - On out_ready: next state IDLE and out_valid drops next cycle.
- Latency: accept edge at cycle 0 -> out_valid high from cycle NCHUNK.
- Minimum initiation interval is NCHUNK+1 cycles. There is no accept in the same cycle as output handoff (in_ready is 0 in DONE).
- CHUNK == WIDTH: BUSY lasts exactly one cycle and latency is 1.
- Back-pressure: out_valid may stay high indefinitely. Outputs must not change while out_valid && !out_ready.
- Reset mid-operation (BUSY or DONE): the operation is aborted with no partial result visible. Outputs take reset values immediately. The first op after release computes correctly with no stale carry.
- q, carry and overflow are only meaningful while out_valid=1. They are registered; no combinational path from inputs to outputs.
- Unsigned wrap is modulo 2^WIDTH.

Decomposition:
- Package chunked_addsub_pkg:
  - state_t enum {IDLE, BUSY, DONE};
  - localparams for the sub encoding (OP_ADD=0, OP_SUB=1);
  - a function computing signed max/min for a given width.
- One sub-module, chunk_adder: CHUNK-bit combinational ripple adder (a, b, cin -> sum, cout). It is instantiated once and muxed by idx.
- Top holds the FSM, operand and result registers, the idx counter, and the saturation logic.

Test Plan:
1. Add (WIDTH=16, CHUNK=4): a1=0x0001, a2=0x0002, sub=0 -> in_ready drops after accept; out_valid after 4 cycles; q=0x0003, carry=0, overflow=0.
2. Wrap/carry: a1=0xFFFF, a2=0x0001, sub=0 -> q=0x0000, carry=1, overflow=0. Also a1=0x7FFF, a2=0x0001 -> q=0x8000, overflow=1; with SAT=1 -> q=0x7FFF.
3. Subtract: a1=0x0001, a2=0x0002, sub=1 -> q=0xFFFF, carry=0, overflow=0. Also a1=0x8000, a2=0x0001 -> q=0x7FFF, overflow=1; with SAT=1 -> q=0x8000.
4. Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> q/carry/overflow stable, in_ready=0, a pulsed in_valid is ignored. Then out_ready=1 -> in_ready=1 on the following cycle and the next op is accepted.
5. Reset mid-op: assert rst_n low during BUSY at idx=2 -> outputs go to 0 and in_ready to 1 without a clock edge. After release, 0x0005+0x0003 -> q=0x0008.
6. Generic widths:
   - WIDTH=4, CHUNK=1: a1=1, a2=2 -> q=3 after 4 cycles; a1=1, a2=1 -> q=2.
   - WIDTH=4, CHUNK=4: latency 1.
